// File: rtl/rvh_l1d_stb_ptw_hazard_if.sv
// PTW/STB hazard tracker bus: walk request/response, STB entry status, replay outputs.
// master = PTW/STB side driving requests and entry status, slave = the hazard tracker.
interface rvh_l1d_stb_ptw_hazard_if #(
    parameter int unsigned STB_ENTRY_NUM     = 8,
    parameter int unsigned PADDR_WIDTH       = 56,
    parameter int unsigned LINE_OFFSET_WIDTH = 6,
    parameter int unsigned PTW_ID_WIDTH      = 1
);
    localparam int unsigned LINE_W = PADDR_WIDTH - LINE_OFFSET_WIDTH;

    logic                              ptw_walk_req_vld_i;
    logic [PTW_ID_WIDTH-1:0]           ptw_walk_req_id_i;
    logic [PADDR_WIDTH-1:0]            ptw_walk_req_addr_i;
    logic                              ptw_walk_resp_vld_i;
    logic                              ptw_walk_resp_rdy_i;
    logic [STB_ENTRY_NUM-1:0]          stb_entry_vld_i;
    logic [STB_ENTRY_NUM*LINE_W-1:0]   stb_entry_line_addr_i;
    logic [STB_ENTRY_NUM-1:0]          stb_entry_evict_done_i;
    logic                              stb_l1d_ptw_replay_vld_o;
    logic [PTW_ID_WIDTH-1:0]           stb_ptw_replay_id_o;
    logic [STB_ENTRY_NUM-1:0]          stb_ptw_drain_mask_o;
    logic                              stb_ptw_hazard_busy_o;

    modport master (
        output ptw_walk_req_vld_i, ptw_walk_req_id_i, ptw_walk_req_addr_i,
               ptw_walk_resp_vld_i, ptw_walk_resp_rdy_i,
               stb_entry_vld_i, stb_entry_line_addr_i, stb_entry_evict_done_i,
        input  stb_l1d_ptw_replay_vld_o, stb_ptw_replay_id_o,
               stb_ptw_drain_mask_o, stb_ptw_hazard_busy_o
    );

    modport slave (
        input  ptw_walk_req_vld_i, ptw_walk_req_id_i, ptw_walk_req_addr_i,
               ptw_walk_resp_vld_i, ptw_walk_resp_rdy_i,
               stb_entry_vld_i, stb_entry_line_addr_i, stb_entry_evict_done_i,
        output stb_l1d_ptw_replay_vld_o, stb_ptw_replay_id_o,
               stb_ptw_drain_mask_o, stb_ptw_hazard_busy_o
    );
endinterface

// File: rtl/rvh_l1d_stb_ptw_hazard.sv
// Tracks STB entries that hit a PTW walk's cache line and pulses a replay once
// all of them have drained, so the walk re-reads up-to-date PTE data.
module rvh_l1d_stb_ptw_hazard #(
    parameter int unsigned STB_ENTRY_NUM     = 8,
    parameter int unsigned PADDR_WIDTH       = 56,
    parameter int unsigned LINE_OFFSET_WIDTH = 6,
    parameter int unsigned PTW_ID_WIDTH      = 1
) (
    input logic                    clk,
    input logic                    rst,
    rvh_l1d_stb_ptw_hazard_if.slave bus
);
    localparam int unsigned LINE_W = PADDR_WIDTH - LINE_OFFSET_WIDTH;

    typedef enum logic [1:0] {IDLE, DRAIN, REPLAY, WALK} state_e;

    state_e                   state_q, state_d;
    logic [STB_ENTRY_NUM-1:0] mask_q, mask_d;
    logic [PTW_ID_WIDTH-1:0]  id_q, id_d;
    logic [STB_ENTRY_NUM-1:0] match;
    logic [LINE_W-1:0]        req_line;
    logic                     resp_hs;

    logic                     replay_q;
    logic [STB_ENTRY_NUM-1:0] drain_mask_q;
    logic                     busy_q;

    assign req_line = bus.ptw_walk_req_addr_i[PADDR_WIDTH-1:LINE_OFFSET_WIDTH];
    assign resp_hs  = bus.ptw_walk_resp_vld_i & bus.ptw_walk_resp_rdy_i;

    // An entry freeing in the request cycle has already written the array, so it is no hazard.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < STB_ENTRY_NUM; i++) begin
            match[i] = bus.stb_entry_vld_i[i]
                     & (bus.stb_entry_line_addr_i[i*LINE_W +: LINE_W] == req_line)
                     & ~bus.stb_entry_evict_done_i[i];
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        id_d    = id_q;
        if (resp_hs) begin
            state_d = IDLE;
            mask_d  = '0;
        end else if (bus.ptw_walk_req_vld_i) begin
            id_d    = bus.ptw_walk_req_id_i;
            mask_d  = match;
            state_d = (|match) ? DRAIN : WALK;
        end else begin
            case (state_q)
                DRAIN: begin
                    // Invalidation without an evict pulse retires the entry just the same.
                    mask_d = mask_q & ~bus.stb_entry_evict_done_i & bus.stb_entry_vld_i;
                    if (mask_d == '0) state_d = REPLAY;
                end
                REPLAY:  state_d = WALK;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are registered off the next-state values so they track state_q exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            id_q         <= '0;
            replay_q     <= 1'b0;
            drain_mask_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            id_q         <= id_d;
            replay_q     <= (state_d == REPLAY);
            drain_mask_q <= (state_d == DRAIN) ? mask_d : '0;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.stb_l1d_ptw_replay_vld_o = replay_q;
    assign bus.stb_ptw_replay_id_o      = id_q;
    assign bus.stb_ptw_drain_mask_o     = drain_mask_q;
    assign bus.stb_ptw_hazard_busy_o    = busy_q;
endmodule

// File: tb/tb_rvh_l1d_stb_ptw_hazard.sv
// Directed bench for the STB/PTW hazard tracker; expected values are hand-derived per scenario.
module tb_rvh_l1d_stb_ptw_hazard;
    localparam int unsigned N      = 8;
    localparam int unsigned PAW    = 56;
    localparam int unsigned OFF    = 6;
    localparam int unsigned IDW    = 1;
    localparam int unsigned LINE_W = PAW - OFF;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;

    rvh_l1d_stb_ptw_hazard_if #(
        .STB_ENTRY_NUM(N), .PADDR_WIDTH(PAW), .LINE_OFFSET_WIDTH(OFF), .PTW_ID_WIDTH(IDW)
    ) bus ();

    rvh_l1d_stb_ptw_hazard #(
        .STB_ENTRY_NUM(N), .PADDR_WIDTH(PAW), .LINE_OFFSET_WIDTH(OFF), .PTW_ID_WIDTH(IDW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int unsigned i, input logic [LINE_W-1:0] v);
        bus.stb_entry_line_addr_i[i*LINE_W +: LINE_W] = v;
    endtask

    // Non-matching default lines, no valid entries, no request/response/evict.
    task automatic clear_inputs();
        bus.ptw_walk_req_vld_i     = 1'b0;
        bus.ptw_walk_req_id_i      = '0;
        bus.ptw_walk_req_addr_i    = '0;
        bus.ptw_walk_resp_vld_i    = 1'b0;
        bus.ptw_walk_resp_rdy_i    = 1'b0;
        bus.stb_entry_vld_i        = '0;
        bus.stb_entry_evict_done_i = '0;
        for (int unsigned i = 0; i < N; i++) set_line(i, LINE_W'(32'h100 + i));
    endtask

    task automatic resp_to_idle(input string tag);
        bus.ptw_walk_resp_vld_i = 1'b1;
        bus.ptw_walk_resp_rdy_i = 1'b1;
        step();
        bus.ptw_walk_resp_vld_i = 1'b0;
        bus.ptw_walk_resp_rdy_i = 1'b0;
        chk(tag, 64'(bus.stb_ptw_hazard_busy_o), 64'd0);
    endtask

    // Entry 3 hits line 0x40; request id 1 at T, evict at T+gap, pulse at T+gap+1.
    task automatic run_single(input int unsigned gap);
        clear_inputs();
        set_line(3, LINE_W'(32'h40));
        bus.stb_entry_vld_i     = 8'h08;
        bus.ptw_walk_req_vld_i  = 1'b1;
        bus.ptw_walk_req_id_i   = 1'b1;
        bus.ptw_walk_req_addr_i = 56'h1008;
        step();
        bus.ptw_walk_req_vld_i  = 1'b0;
        chk("single_mask", 64'(bus.stb_ptw_drain_mask_o), 64'h08);
        chk("single_busy", 64'(bus.stb_ptw_hazard_busy_o), 64'd1);
        chk("single_nopulse_t1", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        for (int unsigned k = 1; k < gap; k++) begin
            step();
            chk("single_hold_mask", 64'(bus.stb_ptw_drain_mask_o), 64'h08);
            chk("single_hold_nopulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        end
        bus.stb_entry_evict_done_i = 8'h08;
        step();
        bus.stb_entry_evict_done_i = '0;
        bus.stb_entry_vld_i        = '0;
        chk("single_pulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd1);
        chk("single_id", 64'(bus.stb_ptw_replay_id_o), 64'd1);
        chk("single_mask_replay", 64'(bus.stb_ptw_drain_mask_o), 64'd0);
        step();
        chk("single_walk_nopulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        chk("single_walk_busy", 64'(bus.stb_ptw_hazard_busy_o), 64'd1);
        resp_to_idle("single_idle");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("rst_busy", 64'(bus.stb_ptw_hazard_busy_o), 64'd0);
        chk("rst_pulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        chk("rst_mask", 64'(bus.stb_ptw_drain_mask_o), 64'd0);
        chk("rst_id", 64'(bus.stb_ptw_replay_id_o), 64'd0);
        step();
        step();
        rst = 1'b1;

        // No hazard: all entries valid on other lines.
        bus.stb_entry_vld_i     = 8'hFF;
        bus.ptw_walk_req_vld_i  = 1'b1;
        bus.ptw_walk_req_addr_i = 56'h1000;
        step();
        bus.ptw_walk_req_vld_i  = 1'b0;
        chk("nohaz_busy", 64'(bus.stb_ptw_hazard_busy_o), 64'd1);
        chk("nohaz_mask", 64'(bus.stb_ptw_drain_mask_o), 64'd0);
        chk("nohaz_nopulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        for (int unsigned k = 0; k < 4; k++) begin
            step();
            chk("nohaz_nopulse_walk", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        end
        resp_to_idle("nohaz_idle");

        run_single(4);

        // Multiple hazards on entries 1 and 5; entry 7 joins the line after the request.
        clear_inputs();
        set_line(1, LINE_W'(32'h40));
        set_line(5, LINE_W'(32'h40));
        bus.stb_entry_vld_i     = 8'h23;
        bus.ptw_walk_req_vld_i  = 1'b1;
        bus.ptw_walk_req_addr_i = 56'h103F;
        step();
        bus.ptw_walk_req_vld_i  = 1'b0;
        chk("multi_mask_t1", 64'(bus.stb_ptw_drain_mask_o), 64'h22);
        step();
        bus.stb_entry_evict_done_i = 8'h20;
        step();
        bus.stb_entry_evict_done_i = '0;
        bus.stb_entry_vld_i        = 8'h83;
        set_line(7, LINE_W'(32'h40));
        chk("multi_mask_t3", 64'(bus.stb_ptw_drain_mask_o), 64'h02);
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            chk("multi_late_store_excl", 64'(bus.stb_ptw_drain_mask_o), 64'h02);
            chk("multi_nopulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        end
        bus.stb_entry_evict_done_i = 8'h02;
        step();
        bus.stb_entry_evict_done_i = '0;
        bus.stb_entry_vld_i        = 8'h81;
        chk("multi_pulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd1);
        step();
        chk("multi_walk_nopulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        resp_to_idle("multi_idle");

        // Same-cycle evict: the only match frees as the request arrives.
        clear_inputs();
        set_line(2, LINE_W'(32'h40));
        bus.stb_entry_vld_i        = 8'h04;
        bus.stb_entry_evict_done_i = 8'h04;
        bus.ptw_walk_req_vld_i     = 1'b1;
        bus.ptw_walk_req_addr_i    = 56'h1000;
        step();
        clear_inputs();
        chk("same_busy", 64'(bus.stb_ptw_hazard_busy_o), 64'd1);
        chk("same_mask", 64'(bus.stb_ptw_drain_mask_o), 64'd0);
        chk("same_nopulse_t1", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        step();
        chk("same_nopulse_t2", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        resp_to_idle("same_idle");

        // Response mid-drain abandons tracking; a later evict must not pulse.
        clear_inputs();
        set_line(4, LINE_W'(32'h40));
        bus.stb_entry_vld_i     = 8'h10;
        bus.ptw_walk_req_vld_i  = 1'b1;
        bus.ptw_walk_req_addr_i = 56'h1000;
        step();
        bus.ptw_walk_req_vld_i  = 1'b0;
        chk("middrain_mask", 64'(bus.stb_ptw_drain_mask_o), 64'h10);
        step();
        resp_to_idle("middrain_idle");
        chk("middrain_mask_idle", 64'(bus.stb_ptw_drain_mask_o), 64'd0);
        bus.stb_entry_evict_done_i = 8'h10;
        step();
        bus.stb_entry_evict_done_i = '0;
        chk("middrain_nopulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        chk("middrain_stay_idle", 64'(bus.stb_ptw_hazard_busy_o), 64'd0);

        // Response during the REPLAY cycle: pulse still visible, then IDLE.
        clear_inputs();
        set_line(6, LINE_W'(32'h40));
        bus.stb_entry_vld_i     = 8'h40;
        bus.ptw_walk_req_vld_i  = 1'b1;
        bus.ptw_walk_req_addr_i = 56'h1000;
        step();
        bus.ptw_walk_req_vld_i     = 1'b0;
        bus.stb_entry_evict_done_i = 8'h40;
        step();
        bus.stb_entry_evict_done_i = '0;
        bus.stb_entry_vld_i        = '0;
        chk("replayresp_pulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd1);
        resp_to_idle("replayresp_idle");
        chk("replayresp_nopulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);

        // Entry invalidated without an evict pulse counts as drained.
        clear_inputs();
        set_line(0, LINE_W'(32'h40));
        bus.stb_entry_vld_i     = 8'h01;
        bus.ptw_walk_req_vld_i  = 1'b1;
        bus.ptw_walk_req_addr_i = 56'h1000;
        step();
        bus.ptw_walk_req_vld_i  = 1'b0;
        chk("inval_mask", 64'(bus.stb_ptw_drain_mask_o), 64'h01);
        bus.stb_entry_vld_i     = '0;
        step();
        chk("inval_pulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd1);
        step();
        chk("inval_walk_nopulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        resp_to_idle("inval_idle");

        // Async reset while draining, asserted between clock edges.
        clear_inputs();
        set_line(3, LINE_W'(32'h40));
        bus.stb_entry_vld_i     = 8'h08;
        bus.ptw_walk_req_vld_i  = 1'b1;
        bus.ptw_walk_req_id_i   = 1'b1;
        bus.ptw_walk_req_addr_i = 56'h1000;
        step();
        bus.ptw_walk_req_vld_i  = 1'b0;
        chk("arst_pre_mask", 64'(bus.stb_ptw_drain_mask_o), 64'h08);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.stb_ptw_hazard_busy_o), 64'd0);
        chk("arst_mask", 64'(bus.stb_ptw_drain_mask_o), 64'd0);
        chk("arst_pulse", 64'(bus.stb_l1d_ptw_replay_vld_o), 64'd0);
        chk("arst_id", 64'(bus.stb_ptw_replay_id_o), 64'd0);
        #1;
        rst = 1'b1;
        run_single(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/rvh_l1d_stb_ptw_hazard.md
# rvh_l1d_stb_ptw_hazard

Store-buffer-side hazard tracker for page-table-walk reads in the L1D. On each PTW walk request it compares the walk's cache-line address against all valid store-buffer (STB) entries and records the matching entries. Once every matching store has drained to the data array, it emits a one-cycle `stb_l1d_ptw_replay_vld_o` pulse. That pulse drives the PTW replay buffer's replay-pending input, so the walk re-reads up-to-date PTE data.

## Interface
- `STB_ENTRY_NUM`, 8, number of STB entries tracked
- `PADDR_WIDTH`, 56, physical address width
- `LINE_OFFSET_WIDTH`, 6, cache-line offset bits ignored in compare
- `PTW_ID_WIDTH`, 1, PTW request id width
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `ptw_walk_req_vld_i`  in  1  PTW walk request issued to L1D this cycle
- `ptw_walk_req_id_i`  in  PTW_ID_WIDTH  walk id (captured, echoed)
- `ptw_walk_req_addr_i`  in  PADDR_WIDTH  walk physical address
- `ptw_walk_resp_vld_i`, `ptw_walk_resp_rdy_i`  in  1 each  walk response handshake
- `stb_entry_vld_i`  in  STB_ENTRY_NUM  per-entry valid
- `stb_entry_line_addr_i`  in  STB_ENTRY_NUM*(PADDR_WIDTH-LINE_OFFSET_WIDTH)  per-entry line address, entry i at slice i
- `stb_entry_evict_done_i`  in  STB_ENTRY_NUM  pulse: entry written to data array and freed
- `stb_l1d_ptw_replay_vld_o`  out  1  one-cycle replay pulse
- `stb_ptw_replay_id_o`  out  PTW_ID_WIDTH  captured walk id
- `stb_ptw_drain_mask_o`  out  STB_ENTRY_NUM  entries the STB must drain with priority
- `stb_ptw_hazard_busy_o`  out  1  tracker not IDLE

## Operation
- Line match: entry i matches when `stb_entry_vld_i[i]` is set, the entry's line address equals `ptw_walk_req_addr_i[PADDR_WIDTH-1:LINE_OFFSET_WIDTH]`, and `stb_entry_evict_done_i[i]` is 0 in the same cycle.
- State machine with states IDLE, DRAIN, REPLAY, WALK. `mask_q` holds the outstanding matching entries. `id_q` holds the walk id.
- Resp handshake (`resp_vld & resp_rdy`) has highest priority in every state:
  - next state is IDLE and `mask_q` is cleared.
  - A request in the same cycle is ignored.
- Request accepted (no resp handshake) in any state restarts tracking:
  - `id_q` is loaded from the request id.
  - `mask_q` is loaded with the match vector.
  - Next state is DRAIN if the match vector is nonzero, otherwise WALK.
- DRAIN:
  - Each cycle, `mask_q <= mask_q & ~evict_done & stb_entry_vld_i`.
  - When this next value is 0, next state is REPLAY.
  - Stores allocated after the request are never added to the mask.
- REPLAY: lasts exactly one cycle, then WALK.
- WALK: holds until a resp handshake or a new request.
- Outputs:
  - `stb_l1d_ptw_replay_vld_o` = (state==REPLAY).
  - `stb_ptw_drain_mask_o` = `mask_q` while in DRAIN, otherwise 0.
  - `stb_ptw_hazard_busy_o` = (state!=IDLE).
  - `stb_ptw_replay_id_o` = `id_q`.
- A resp handshake in the REPLAY cycle still sees the pulse that cycle, and the next state is IDLE.

## Timing
- Reset (async, `rst`=0): state=IDLE, `mask_q`=0, `id_q`=0. All outputs are 0 immediately, independent of `clk`.
- Request sampled at cycle T → DRAIN or WALK visible at T+1. Zero-match case: busy at T+1 with no pulse ever.
- Last outstanding evict pulse at cycle E (in DRAIN) → REPLAY (pulse) at E+1 → WALK at E+2.
- Minimum request-to-pulse latency: T+2 (single match evicted at T+1).
- Resp handshake at cycle R → IDLE at R+1; busy drops at R+1.
- An entry that goes invalid without an evict pulse is cleared from the mask in the same way as an evicted one.
- No combinational path from any input to any output.

## Test plan
- No hazard: entries 0–7 valid with lines ≠ 0x40; request addr 0x1000 at T → busy=1 and drain_mask=0 at T+1; no replay pulse; resp handshake at T+5 → busy=0 at T+6.
- Single hazard: entry 3 line = 0x1000>>6; request 0x1008, id=1 at T → drain_mask=0x08 at T+1; evict_done[3] at T+4 → replay_vld=1 and replay_id=1 at T+5 only; WALK at T+6.
- Multiple hazards: entries 1 and 5 match; evict 5 at T+2 → mask=0x02 at T+3; evict 1 at T+6 → pulse at T+7.
- Same-cycle evict: entry 2 matches but evict_done[2]=1 in the request cycle → WALK at T+1, no pulse.
- Response mid-drain: entry 4 matches, resp handshake at T+2 → IDLE at T+3; no pulse even if evict_done[4] arrives at T+3.
- Async reset mid-DRAIN: `rst`=0 between clock edges → busy, drain_mask and replay_vld all 0 before the next edge; after release, a new request behaves per the single-hazard case.
